// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the pipeline stages.
//   PCS_*     : encodings of decode's next-PC select (pcsource).
//   NOP_INST  : instruction word used for an empty IF/ID slot (sll $0,$0,0).
//   if_state_e: fetch-stage state (REQ = request outstanding, FULL = skid buffer holds a word).
//   fetch_word_t: one fetched instruction with its PC+4.
package pipe_pkg;

   localparam logic [1:0]  PCS_SEQ  = 2'b00;
   localparam logic [1:0]  PCS_BR   = 2'b01;
   localparam logic [1:0]  PCS_JR   = 2'b10;
   localparam logic [1:0]  PCS_J    = 2'b11;

   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   typedef enum logic {
      IF_REQ  = 1'b0,
      IF_FULL = 1'b1
   } if_state_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc4;
   } fetch_word_t;

endpackage

// File: rtl/pipe_if_stage_mux4x32.sv
// mux4x32: 4-to-1 multiplexer on 32-bit words.
//   a0..a3 : data inputs, selected by s = 0..3
//   s      : select
//   y      : selected word
module mux4x32 (
   input  logic [31:0] a0,
   input  logic [31:0] a1,
   input  logic [31:0] a2,
   input  logic [31:0] a3,
   input  logic [1:0]  s,
   output logic [31:0] y
);

   always_comb begin
      unique case (s)
         2'd0:    y = a0;
         2'd1:    y = a1;
         2'd2:    y = a2;
         default: y = a3;
      endcase
   end

endmodule

// File: rtl/pipe_if_stage.sv
// pipe_if_stage: instruction-fetch stage.
//   clock, reset           : clock, synchronous active-high reset
//   bpc, jpc, rpc          : branch / jump / register targets from decode
//   pcsource, wpcir        : next-PC select and decode-advance from decode
//   imem_req/addr/ack/rdata: req/ack instruction-memory port (ack may be same cycle)
//   inst, dpc4, dvalid     : IF/ID pipeline register
// A single skid buffer absorbs a word that completes while decode is stalled,
// so the request is never held waiting on decode. A redirect that arrives
// while a fetch is still outstanding is parked in redir_pc and applied when
// that fetch (the delay slot) completes.
module pipe_if_stage
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] bpc,
   input  logic [31:0] jpc,
   input  logic [31:0] rpc,
   input  logic [1:0]  pcsource,
   input  logic        wpcir,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] dpc4,
   output logic        dvalid
);

   if_state_e   state;
   logic [31:0] pc;
   fetch_word_t skid;
   logic        redir_pend;
   logic [31:0] redir_pc;

   logic [31:0] pc4;
   logic [31:0] tgt;
   logic [31:0] next_pc;
   logic        slot_free;
   logic        redir_now;

   assign pc4       = pc + 32'd4;
   assign slot_free = wpcir | ~dvalid;
   // pcsource is only meaningful while decode holds a real instruction it is retiring
   assign redir_now = wpcir & dvalid & (pcsource != PCS_SEQ);

   // Input 0 is never selected when redir_now is true; pc4 keeps it defined.
   mux4x32 u_tgt_mux (
      .a0 (pc4),
      .a1 (bpc),
      .a2 (rpc),
      .a3 (jpc),
      .s  (pcsource),
      .y  (tgt)
   );

   // Address of the fetch after the one completing now.
   always_comb begin
      if (redir_now)       next_pc = tgt;
      else if (redir_pend) next_pc = redir_pc;
      else                 next_pc = pc4;
   end

   assign imem_req  = ~reset & (state == IF_REQ);
   assign imem_addr = pc;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IF_REQ;
         pc         <= RESET_PC;
         skid       <= '0;
         redir_pend <= 1'b0;
         redir_pc   <= '0;
         inst       <= NOP_INST;
         dpc4       <= '0;
         dvalid     <= 1'b0;
      end else begin
         unique case (state)
            IF_REQ: begin
               if (imem_ack) begin
                  pc         <= next_pc;
                  redir_pend <= 1'b0;
                  if (slot_free) begin
                     inst   <= imem_rdata;
                     dpc4   <= pc4;
                     dvalid <= 1'b1;
                  end else begin
                     skid  <= '{inst: imem_rdata, pc4: pc4};
                     state <= IF_FULL;
                  end
               end else begin
                  if (redir_now) begin
                     redir_pend <= 1'b1;
                     redir_pc   <= tgt;
                  end
                  if (slot_free) begin
                     inst   <= NOP_INST;
                     dvalid <= 1'b0;
                  end
               end
            end
            IF_FULL: begin
               // No request for pc is outstanding yet, so a redirect can retarget it directly.
               if (redir_now) pc <= tgt;
               if (slot_free) begin
                  inst   <= skid.inst;
                  dpc4   <= skid.pc4;
                  dvalid <= 1'b1;
                  state  <= IF_REQ;
               end
            end
            default: state <= IF_REQ;
         endcase
      end
   end

endmodule

// File: doc/pipe_if_stage.md
Name: pipe_if_stage

Overview:
- Instruction-fetch stage of the five-stage pipelined CPU.
- Owns the PC and drives a req/ack instruction-memory port that may insert wait states.
- Produces the IF/ID pipeline register (inst, dpc4) that feeds decode.
- Consumes decode's next-PC controls (bpc, jpc, rpc, pcsource, wpcir) and honours the one-instruction branch delay slot.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clock  input  1  system clock; all state on the rising edge.
- reset  input  1  synchronous, active-high reset.
- bpc  input  32  branch target from decode.
- jpc  input  32  jump target from decode.
- rpc  input  32  register target (jr) from decode's forwarded rs value.
- pcsource  input  2  next-PC select: 00 sequential, 01 bpc, 10 rpc, 11 jpc. Valid only while dvalid=1.
- wpcir  input  1  1 = decode advances this cycle; 0 = load-use stall.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address, word aligned.
- imem_ack  input  1  read data valid; may be asserted in the same cycle as imem_req.
- imem_rdata  input  32  instruction word, sampled when imem_ack=1.
- inst  output  32  IF/ID instruction; 0 (sll $0 = NOP) when empty.
- dpc4  output  32  IF/ID PC+4 of inst.
- dvalid  output  1  IF/ID holds a real instruction.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high, sampled on the rising clock edge.
- Reset values:
  - pc=RESET_PC, state=REQ.
  - inst=0, dpc4=0, dvalid=0.
  - redir_pend=0, redir_pc=0, buf=0.
  - imem_req forced 0 during the reset cycle; asserted with imem_addr=RESET_PC from the first cycle after reset.
  - The instruction memory shares the reset, so no stale ack arrives after reset.
- States:
  - REQ: imem_req=1, imem_addr=pc. pc must not change until imem_ack.
  - FULL: one fetched word sits in the skid buffer buf with pc4 in bpc4; imem_req=0.
- Slot free: IF/ID may load this cycle when (wpcir | !dvalid).
- Redirect sample: when wpcir & dvalid & pcsource!=00, tgt = mux(pcsource: bpc / rpc / jpc).
  - The instruction currently in flight or buffered is the delay slot and is always delivered.
- Next fetch address, computed when a fetch completes (REQ & ack):
  - sample this cycle: tgt;
  - else redir_pend: redir_pc, and clear redir_pend;
  - else pc+4.
- Redirect sampled without a completing fetch: set redir_pend=1, redir_pc=tgt.
  - If state=FULL at that moment, load pc=tgt directly instead; no request for pc has been issued.
- REQ & ack & slot free: IF/ID <= {imem_rdata, pc+4}, dvalid=1; pc <= next address; stay in REQ. This gives back-to-back fetch at 1 instr/cycle with zero-wait memory.
- REQ & ack & slot busy: buf <= rdata, bpc4 <= pc+4; pc <= next address; go to FULL.
- FULL & slot free: IF/ID <= buf, dvalid=1; go to REQ.
- Slot free with nothing to deliver: IF/ID <= bubble (inst=0, dvalid=0, dpc4 held).
- Slot busy (dvalid & !wpcir): IF/ID holds all values unchanged.
- pcsource is ignored while dvalid=0.
- At most one redirect can be pending: decode cannot accept a second branch before its delay slot is delivered.
- Reset mid-fetch: in-flight request abandoned, pending redirect cleared, fetch restarts at RESET_PC.
- PC arithmetic is modulo 2^32 (wrap at 0xFFFFFFFC to 0).

Decomposition:
- Shared package pipe_pkg:
  - pcsource encodings PCS_SEQ=2'b00, PCS_BR=2'b01, PCS_JR=2'b10, PCS_J=2'b11;
  - NOP_INST=32'h0;
  - fetch state encoding IF_REQ / IF_FULL.
- Target select reuses the existing mux4x32 (input order as pcsource). No other sub-module; PC, skid buffer, redirect register and FSM stay in this block.

Test Plan:
1. Zero-wait memory (ack=req combinational), wpcir=1, after reset → imem_addr 0,4,8,… on consecutive cycles; dpc4 4,8,12,…; dvalid=1 from the second cycle.
2. Memory with 2 wait states → each address held 3 cycles with imem_req=1; IF/ID shows inst=0, dvalid=0 bubbles between real instructions.
3. Zero-wait, wpcir=0 for 3 cycles while dvalid=1 → one word captured, state FULL, imem_req=0, inst/dpc4 frozen; on wpcir=1 the buffered word appears next cycle, fetch resumes at the following address with no skip or duplicate.
4. Beq at 0x10 with zero-wait memory; while it is in D, pcsource=01, bpc=0x100 → fetch sequence 0x10, 0x14, 0x100; 0x18 never requested; 0x14 (delay slot) reaches IF/ID with dpc4=0x18.
5. Same as 4 with 2 wait states on the 0x14 fetch → redir_pend set; after 0x14's ack the next imem_addr is 0x100. Repeat with pcsource=10, rpc=0x2000 and pcsource=11, jpc=0x0400_0000.
6. Reset asserted one cycle mid-wait at addr 0x40 → the following cycle imem_addr=RESET_PC, dvalid=0, inst=0, no redirect applied; a normal stream resumes.
